// File: rtl/raisin64_pkg.sv
// Shared raisin64 memory-path definitions: access width encodings, bridge
// state encodings and small lane helpers used by the dmem bridge.
package raisin64_pkg;

  typedef enum logic [1:0] {
    W64 = 2'd0,
    W32 = 2'd1,
    W16 = 2'd2,
    W8  = 2'd3
  } dmem_width_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_e;

  function automatic logic [3:0] width_bytes(input logic [1:0] w);
    logic [3:0] nb;
    case (w)
      W64:     nb = 4'd8;
      W32:     nb = 4'd4;
      W16:     nb = 4'd2;
      W8:      nb = 4'd1;
      default: nb = 4'd8;
    endcase
    return nb;
  endfunction

  // Natural alignment: the low address bits covered by the size must be zero.
  function automatic logic is_aligned(input logic [2:0] off, input logic [1:0] w);
    logic [3:0] nb;
    nb = width_bytes(w);
    return ((off & (nb[2:0] - 3'd1)) == 3'd0);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering between the LSB-justified memory unit view and
// the big-endian 64-bit bus (lane 0 = bits 63:56, enabled by be[7]).
module dmem_lane_align
  import raisin64_pkg::*;
(
  input  logic [1:0]  width,
  input  logic [2:0]  offset,
  input  logic [63:0] store_data,
  input  logic [63:0] load_data,
  output logic [7:0]  be,
  output logic [63:0] wdata,
  output logic [63:0] rdata
);

  logic [3:0]  nb_s;
  logic [6:0]  nbits_s;
  logic [6:0]  obits_s;
  logic [6:0]  wshift_s;
  logic [63:0] low_mask_s;
  logic [63:0] top_mask_s;
  logic        ok_s;

  // Build masks/shifts from the access size and lane offset.
  always_comb begin
    nb_s       = width_bytes(width);
    nbits_s    = {nb_s, 3'b000};
    obits_s    = {1'b0, offset, 3'b000};
    wshift_s   = 7'd64 - obits_s - nbits_s;
    low_mask_s = ~(64'hFFFF_FFFF_FFFF_FFFF << nbits_s);
    top_mask_s = ~(64'hFFFF_FFFF_FFFF_FFFF >> nbits_s);
    ok_s       = is_aligned(offset, width);
    if (ok_s) begin
      be    = (8'hFF << (4'd8 - nb_s)) >> offset;
      wdata = (store_data & low_mask_s) << wshift_s;
      rdata = (load_data << obits_s) & top_mask_s;
    end else begin
      be    = 8'h00;
      wdata = 64'd0;
      rdata = 64'd0;
    end
  end

endmodule

// File: rtl/dmem_bridge.sv
// Bridges single-cycle memory-unit strobes onto a req/ack 64-bit bus, with
// alignment/conflict checking and a bus timeout.
module dmem_bridge
  import raisin64_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] dmem_addr,
  input  logic [63:0] dmem_dout,
  input  logic [1:0]  dmem_width,
  input  logic        dmem_rstrobe,
  input  logic        dmem_wstrobe,
  output logic [63:0] dmem_din,
  output logic        dmem_cycle_complete,
  output logic        dmem_fault,
  output logic [60:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_be,
  output logic        bus_we,
  output logic        bus_req,
  input  logic        bus_ack,
  input  logic [63:0] bus_rdata
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  dmem_state_e state_r;
  dmem_state_e state_next_s;
  logic [1:0]  width_r;
  logic [2:0]  offset_r;
  logic [15:0] cnt_r;

  logic        start_bus_s;
  logic        fault_done_s;
  logic        ack_done_s;
  logic        timeout_s;
  logic        strobe_any_s;
  logic        aligned_s;

  logic [1:0]  sel_width_s;
  logic [2:0]  sel_offset_s;
  logic [7:0]  be_s;
  logic [63:0] wdata_s;
  logic [63:0] rdata_s;

  // In IDLE the aligner sees the incoming request; afterwards the captured one.
  always_comb begin
    if (state_r == ST_IDLE) begin
      sel_width_s  = dmem_width;
      sel_offset_s = dmem_addr[2:0];
    end else begin
      sel_width_s  = width_r;
      sel_offset_s = offset_r;
    end
  end

  dmem_lane_align u_align (
    .width      (sel_width_s),
    .offset     (sel_offset_s),
    .store_data (dmem_dout),
    .load_data  (bus_rdata),
    .be         (be_s),
    .wdata      (wdata_s),
    .rdata      (rdata_s)
  );

  // Next-state and transaction event decode.
  always_comb begin
    state_next_s = state_r;
    start_bus_s  = 1'b0;
    fault_done_s = 1'b0;
    ack_done_s   = 1'b0;
    timeout_s    = 1'b0;
    strobe_any_s = dmem_rstrobe | dmem_wstrobe;
    aligned_s    = is_aligned(dmem_addr[2:0], dmem_width);
    case (state_r)
      ST_IDLE: begin
        if (strobe_any_s) begin
          if ((dmem_rstrobe & dmem_wstrobe) || !aligned_s) begin
            state_next_s = ST_DONE;
            fault_done_s = 1'b1;
          end else begin
            state_next_s = ST_BUS;
            start_bus_s  = 1'b1;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BUS: begin
        if (bus_ack) begin
          state_next_s = ST_DONE;
          ack_done_s   = 1'b1;
        end else if (cnt_r == TO_LAST) begin
          state_next_s = ST_DONE;
          timeout_s    = 1'b1;
        end else begin
          state_next_s = ST_BUS;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Registered bus/memory-unit outputs; bus fields freeze for the whole BUS phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      width_r             <= 2'd0;
      offset_r            <= 3'd0;
      cnt_r               <= 16'd0;
      dmem_din            <= 64'd0;
      dmem_cycle_complete <= 1'b0;
      dmem_fault          <= 1'b0;
      bus_addr            <= 61'd0;
      bus_wdata           <= 64'd0;
      bus_be              <= 8'd0;
      bus_we              <= 1'b0;
      bus_req             <= 1'b0;
    end else begin
      dmem_cycle_complete <= fault_done_s | ack_done_s | timeout_s;
      dmem_fault          <= fault_done_s | timeout_s;
      if (start_bus_s) begin
        width_r   <= dmem_width;
        offset_r  <= dmem_addr[2:0];
        cnt_r     <= 16'd0;
        bus_addr  <= dmem_addr[63:3];
        bus_we    <= dmem_wstrobe;
        bus_be    <= be_s;
        bus_wdata <= dmem_wstrobe ? wdata_s : 64'd0;
        bus_req   <= 1'b1;
      end else if (ack_done_s || timeout_s) begin
        bus_req <= 1'b0;
        bus_we  <= 1'b0;
        if (ack_done_s && !bus_we) begin
          dmem_din <= rdata_s;
        end
      end else if (state_r == ST_BUS) begin
        cnt_r <= cnt_r + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed self-checking bench for dmem_bridge; a second instance with a
// short timeout exercises the no-ack fault path.
module tb_dmem_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] dmem_addr, dmem_dout, bus_rdata;
  logic [1:0]  dmem_width;
  logic        dmem_rstrobe, dmem_wstrobe, bus_ack, t_rstrobe;

  logic [63:0] dmem_din, bus_wdata, t_din, t_wdata;
  logic        dmem_cycle_complete, dmem_fault, bus_we, bus_req;
  logic        t_complete, t_fault, t_we, t_req;
  logic [60:0] bus_addr, t_addr;
  logic [7:0]  bus_be, t_be;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_bridge dut (
    .clk(clk), .rst(rst), .dmem_addr(dmem_addr), .dmem_dout(dmem_dout),
    .dmem_width(dmem_width), .dmem_rstrobe(dmem_rstrobe), .dmem_wstrobe(dmem_wstrobe),
    .dmem_din(dmem_din), .dmem_cycle_complete(dmem_cycle_complete), .dmem_fault(dmem_fault),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_we(bus_we),
    .bus_req(bus_req), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  dmem_bridge #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst(rst), .dmem_addr(dmem_addr), .dmem_dout(dmem_dout),
    .dmem_width(dmem_width), .dmem_rstrobe(t_rstrobe), .dmem_wstrobe(1'b0),
    .dmem_din(t_din), .dmem_cycle_complete(t_complete), .dmem_fault(t_fault),
    .bus_addr(t_addr), .bus_wdata(t_wdata), .bus_be(t_be), .bus_we(t_we),
    .bus_req(t_req), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (bus_req !== 1'b0 || bus_we !== 1'b0) begin failures++; $display("FAIL reset_ctrl: req=%b we=%b expected 0 0", bus_req, bus_we); end
    checks++; if (dmem_cycle_complete !== 1'b0 || dmem_fault !== 1'b0) begin failures++; $display("FAIL reset_cmpl: complete=%b fault=%b expected 0 0", dmem_cycle_complete, dmem_fault); end
    checks++; if (dmem_din !== 64'd0 || bus_wdata !== 64'd0 || bus_addr !== 61'd0 || bus_be !== 8'd0) begin failures++; $display("FAIL reset_data: din=%h wdata=%h addr=%h be=%h expected all 0", dmem_din, bus_wdata, bus_addr, bus_be); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_read64();
    dmem_addr = 64'h1000; dmem_width = 2'd0; dmem_rstrobe = 1'b1;
    step();
    dmem_rstrobe = 1'b0;
    checks++; if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_be !== 8'hFF) begin failures++; $display("FAIL rd64_bus: req=%b we=%b be=%h expected 1 0 ff", bus_req, bus_we, bus_be); end
    checks++; if (bus_addr !== 61'h200) begin failures++; $display("FAIL rd64_addr: got %h expected 200", bus_addr); end
    checks++; if (dmem_cycle_complete !== 1'b0) begin failures++; $display("FAIL rd64_early: complete=%b expected 0", dmem_cycle_complete); end
    bus_ack = 1'b1; bus_rdata = 64'h0123_4567_89AB_CDEF;
    step();
    bus_ack = 1'b0;
    checks++; if (dmem_cycle_complete !== 1'b1 || dmem_fault !== 1'b0 || bus_req !== 1'b0) begin failures++; $display("FAIL rd64_cmpl: complete=%b fault=%b req=%b expected 1 0 0", dmem_cycle_complete, dmem_fault, bus_req); end
    checks++; if (dmem_din !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("FAIL rd64_data: got %h expected 0123456789abcdef", dmem_din); end
    step();
    checks++; if (dmem_cycle_complete !== 1'b0) begin failures++; $display("FAIL rd64_pulse: complete=%b expected 0", dmem_cycle_complete); end
  endtask

  task automatic test_read8();
    dmem_addr = 64'h1005; dmem_width = 2'd3; dmem_rstrobe = 1'b1;
    step();
    dmem_rstrobe = 1'b0;
    checks++; if (bus_be !== 8'h04 || bus_req !== 1'b1) begin failures++; $display("FAIL rd8_be: be=%h req=%b expected 04 1", bus_be, bus_req); end
    bus_ack = 1'b1; bus_rdata = 64'h0123_4567_89AB_CDEF;
    step();
    bus_ack = 1'b0;
    checks++; if (dmem_cycle_complete !== 1'b1 || dmem_din !== 64'hAB00_0000_0000_0000) begin failures++; $display("FAIL rd8_data: complete=%b din=%h expected 1 ab00000000000000", dmem_cycle_complete, dmem_din); end
    step();
  endtask

  task automatic test_read32_ignore_strobe();
    dmem_addr = 64'h1004; dmem_width = 2'd1; dmem_rstrobe = 1'b1;
    step();
    dmem_rstrobe = 1'b0;
    checks++; if (bus_be !== 8'h0F) begin failures++; $display("FAIL rd32_be: got %h expected 0f", bus_be); end
    dmem_wstrobe = 1'b1; dmem_addr = 64'h5000; dmem_width = 2'd0;
    step();
    dmem_wstrobe = 1'b0;
    checks++; if (bus_we !== 1'b0 || bus_addr !== 61'h200 || bus_be !== 8'h0F || bus_req !== 1'b1) begin failures++; $display("FAIL busy_strobe: we=%b addr=%h be=%h req=%b expected 0 200 0f 1", bus_we, bus_addr, bus_be, bus_req); end
    bus_ack = 1'b1; bus_rdata = 64'h0123_4567_89AB_CDEF;
    step();
    bus_ack = 1'b0;
    checks++; if (dmem_cycle_complete !== 1'b1 || dmem_din !== 64'h89AB_CDEF_0000_0000) begin failures++; $display("FAIL rd32_data: complete=%b din=%h expected 1 89abcdef00000000", dmem_cycle_complete, dmem_din); end
    step();
    step();
    checks++; if (bus_req !== 1'b0 || dmem_cycle_complete !== 1'b0) begin failures++; $display("FAIL busy_queued: req=%b complete=%b expected 0 0", bus_req, dmem_cycle_complete); end
  endtask

  task automatic test_write16();
    dmem_addr = 64'h2002; dmem_width = 2'd2; dmem_dout = 64'h1234_5678_9ABC_BEEF; dmem_wstrobe = 1'b1;
    step();
    dmem_wstrobe = 1'b0; dmem_dout = 64'd0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus_wdata !== 64'h0000_BEEF_0000_0000 || bus_be !== 8'h30 || bus_we !== 1'b1 || bus_req !== 1'b1) begin failures++; $display("FAIL wr16_hold%0d: wdata=%h be=%h we=%b req=%b expected 0000beef00000000 30 1 1", i, bus_wdata, bus_be, bus_we, bus_req); end
      checks++; if (dmem_cycle_complete !== 1'b0) begin failures++; $display("FAIL wr16_early%0d: complete=%b expected 0", i, dmem_cycle_complete); end
      if (i == 2) bus_ack = 1'b1;
      step();
    end
    bus_ack = 1'b0;
    checks++; if (dmem_cycle_complete !== 1'b1 || dmem_fault !== 1'b0) begin failures++; $display("FAIL wr16_cmpl: complete=%b fault=%b expected 1 0", dmem_cycle_complete, dmem_fault); end
    checks++; if (dmem_din !== 64'h89AB_CDEF_0000_0000) begin failures++; $display("FAIL wr16_din: got %h expected 89abcdef00000000", dmem_din); end
    step();
    checks++; if (dmem_cycle_complete !== 1'b0) begin failures++; $display("FAIL wr16_pulse: complete=%b expected 0", dmem_cycle_complete); end
  endtask

  task automatic test_misaligned();
    dmem_addr = 64'h3002; dmem_width = 2'd1; dmem_rstrobe = 1'b1;
    step();
    dmem_rstrobe = 1'b0;
    checks++; if (bus_req !== 1'b0 || dmem_cycle_complete !== 1'b1 || dmem_fault !== 1'b1) begin failures++; $display("FAIL misalign: req=%b complete=%b fault=%b expected 0 1 1", bus_req, dmem_cycle_complete, dmem_fault); end
    checks++; if (dmem_din !== 64'h89AB_CDEF_0000_0000) begin failures++; $display("FAIL misalign_din: got %h expected 89abcdef00000000", dmem_din); end
    step();
    checks++; if (dmem_cycle_complete !== 1'b0 || dmem_fault !== 1'b0 || bus_req !== 1'b0) begin failures++; $display("FAIL misalign_after: complete=%b fault=%b req=%b expected 0 0 0", dmem_cycle_complete, dmem_fault, bus_req); end
  endtask

  task automatic test_conflict();
    dmem_addr = 64'h4000; dmem_width = 2'd0; dmem_rstrobe = 1'b1; dmem_wstrobe = 1'b1;
    step();
    dmem_rstrobe = 1'b0; dmem_wstrobe = 1'b0;
    checks++; if (bus_req !== 1'b0 || dmem_cycle_complete !== 1'b1 || dmem_fault !== 1'b1) begin failures++; $display("FAIL conflict: req=%b complete=%b fault=%b expected 0 1 1", bus_req, dmem_cycle_complete, dmem_fault); end
    step();
  endtask

  task automatic test_timeout();
    int req_cycles;
    logic done;
    dmem_addr = 64'h1000; dmem_width = 2'd0; t_rstrobe = 1'b1;
    step();
    t_rstrobe = 1'b0;
    bus_ack = 1'b1; bus_rdata = 64'hFEDC_BA98_7654_3210;
    step();
    bus_ack = 1'b0;
    checks++; if (t_complete !== 1'b1 || t_din !== 64'hFEDC_BA98_7654_3210) begin failures++; $display("FAIL to_load: complete=%b din=%h expected 1 fedcba9876543210", t_complete, t_din); end
    checks++; if (dmem_cycle_complete !== 1'b0) begin failures++; $display("FAIL stray_ack_idle: complete=%b expected 0", dmem_cycle_complete); end
    step();
    dmem_addr = 64'h6000; t_rstrobe = 1'b1;
    step();
    t_rstrobe = 1'b0;
    req_cycles = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (t_complete === 1'b1) done = 1'b1;
      else begin
        if (t_req === 1'b1) req_cycles++;
        step();
      end
    end
    checks++; if (!done) begin failures++; $display("FAIL to_wait: no completion within 20 cycles"); end
    checks++; if (req_cycles != 4) begin failures++; $display("FAIL to_req_cycles: got %0d expected 4", req_cycles); end
    checks++; if (t_fault !== 1'b1 || t_req !== 1'b0) begin failures++; $display("FAIL to_fault: fault=%b req=%b expected 1 0", t_fault, t_req); end
    checks++; if (t_din !== 64'hFEDC_BA98_7654_3210) begin failures++; $display("FAIL to_din: got %h expected fedcba9876543210", t_din); end
    step();
  endtask

  task automatic test_reset_in_bus();
    dmem_addr = 64'h7008; dmem_width = 2'd0; dmem_dout = 64'hAAAA_5555_AAAA_5555; dmem_wstrobe = 1'b1;
    step();
    dmem_wstrobe = 1'b0;
    step();
    checks++; if (bus_req !== 1'b1 || bus_we !== 1'b1) begin failures++; $display("FAIL rstbus_pre: req=%b we=%b expected 1 1", bus_req, bus_we); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus_req !== 1'b0 || bus_we !== 1'b0 || dmem_cycle_complete !== 1'b0 || dmem_fault !== 1'b0) begin failures++; $display("FAIL rstbus_ctrl: req=%b we=%b complete=%b fault=%b expected 0 0 0 0", bus_req, bus_we, dmem_cycle_complete, dmem_fault); end
    checks++; if (bus_addr !== 61'd0 || bus_wdata !== 64'd0 || bus_be !== 8'd0 || dmem_din !== 64'd0) begin failures++; $display("FAIL rstbus_data: addr=%h wdata=%h be=%h din=%h expected all 0", bus_addr, bus_wdata, bus_be, dmem_din); end
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    step();
    checks++; if (dmem_cycle_complete !== 1'b0 || bus_req !== 1'b0) begin failures++; $display("FAIL rstbus_stray: complete=%b req=%b expected 0 0", dmem_cycle_complete, bus_req); end
  endtask

  initial begin
    rst = 1'b1; dmem_addr = 64'd0; dmem_dout = 64'd0; dmem_width = 2'd0;
    dmem_rstrobe = 1'b0; dmem_wstrobe = 1'b0; t_rstrobe = 1'b0;
    bus_ack = 1'b0; bus_rdata = 64'd0;
    test_reset();
    test_read64();
    test_read8();
    test_read32_ignore_strobe();
    test_write16();
    test_misaligned();
    test_conflict();
    test_timeout();
    test_reset_in_bus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles bus_req is held without bus_ack before a fault.
REQ-002 SHALL have port clk, input, 1, the single clock; one clock, reset is synchronous and active-high.
REQ-003 SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-004 SHALL have port dmem_addr, input, 64, the byte address from the memory unit.
REQ-005 SHALL have port dmem_dout, input, 64, the store data, LSB-justified for narrow widths.
REQ-006 SHALL have port dmem_width, input, 2, the access size: 0=64, 1=32, 2=16, 3=8 bit.
REQ-007 SHALL have ports dmem_rstrobe and dmem_wstrobe, input, 1 each, one-cycle start pulses for a read and a write.
REQ-008 SHALL have port dmem_din, output, 64, the read data, MSB-justified with lower bits zero.
REQ-009 SHALL have port dmem_cycle_complete, output, 1, a one-cycle completion pulse.
REQ-010 SHALL have port dmem_fault, output, 1, valid with dmem_cycle_complete, flagging a misaligned, conflicting or timed-out access.
REQ-011 SHALL have port bus_addr, output, 61, the 64-bit word address (dmem_addr[63:3]).
REQ-012 SHALL have ports bus_wdata (output, 64), bus_be (output, 8) and bus_we (output, 1); byte 0 is bits 63:56 (big-endian) and bus_be[7] enables byte 0.
REQ-013 SHALL have ports bus_req (output, 1), bus_ack (input, 1) and bus_rdata (input, 64); bus_rdata is valid in the cycle bus_ack is high.

Function
REQ-014 SHALL implement the states IDLE, BUS and DONE.
REQ-015 In IDLE, a strobe SHALL capture the address, data and width, and SHALL move to BUS in the next cycle with bus_req=1.
REQ-016 bus_req, bus_addr, bus_we, bus_be and bus_wdata SHALL be held stable while in BUS until bus_ack is sampled high.
REQ-017 On bus_ack in BUS, the block SHALL deassert bus_req in the next cycle, enter DONE, and pulse dmem_cycle_complete in that DONE cycle.
REQ-018 DONE SHALL return to IDLE after exactly one cycle, giving a minimum strobe-to-complete latency of 2 cycles (ack in the first BUS cycle).
REQ-019 Alignment SHALL require dmem_addr to be a multiple of the access size; a misaligned access SHALL skip BUS, go IDLE->DONE, and set dmem_fault=1.
REQ-020 Simultaneous rstrobe and wstrobe SHALL be treated as a fault handled like a misaligned access, with no bus cycle.
REQ-021 A read SHALL take lane offset o=addr[2:0] and set dmem_din[63 -: N] = bus_rdata[63-8*o -: N] with all other bits zero, where N is the access width in bits.
REQ-022 A write SHALL set bus_wdata[63-8*o -: N] = dmem_dout[N-1:0] with all other bits zero, and SHALL set bus_be to the N/8 contiguous lanes starting at lane o.
REQ-023 A read SHALL drive bus_be for the accessed lanes and bus_we=0.
REQ-024 dmem_din SHALL hold its value until the next read completes; write and fault completions SHALL leave it unchanged.
REQ-025 A 16-bit (bit-width-sufficient) cycle counter SHALL count BUS cycles; on reaching TIMEOUT_CYCLES without ack, the block SHALL drop bus_req, enter DONE, and set dmem_fault=1.
REQ-026 A bus_ack arriving outside BUS SHALL be ignored.
REQ-027 Strobes arriving outside IDLE SHALL be ignored.
REQ-028 dmem_fault SHALL be 0 whenever dmem_cycle_complete is 0.

Reset
REQ-029 When rst=1 at a clk edge, the block SHALL go to state IDLE.
REQ-030 Reset SHALL clear dmem_din, bus_addr, bus_wdata, bus_be and the counter, and SHALL drive bus_req, bus_we, dmem_cycle_complete and dmem_fault to 0.
REQ-031 Reset during BUS SHALL abandon the transfer with no completion pulse, and a later ack from that transfer SHALL be ignored.

Structure
REQ-032 The width encoding constants (W64/W32/W16/W8) and the state encodings SHALL be placed in the shared raisin64 package used by ex_memory.
REQ-033 Lane shifting and byte-enable generation SHALL be a combinational sub-module dmem_lane_align; the state machine and counter SHALL stay in dmem_bridge.

Verification
REQ-034 A 64-bit read at 0x1000 with bus_rdata=0x0123456789ABCDEF and ack in the first BUS cycle SHALL produce complete 2 cycles after the strobe, with dmem_din=0x0123456789ABCDEF and bus_be=0xFF.
REQ-035 An 8-bit read at 0x1005 with the same rdata SHALL produce dmem_din=0xAB00000000000000 and bus_be=0x04.
REQ-036 A 16-bit write at 0x2002 with dmem_dout=0xBEEF SHALL produce bus_wdata=0x0000BEEF00000000, bus_be=0x30 and bus_we=1, held for a 3-cycle ack delay, followed by one complete pulse with fault=0.
REQ-037 A 32-bit read at 0x3002 (misaligned) SHALL produce no bus_req, and complete with fault=1 one cycle after the strobe.
REQ-038 With TIMEOUT_CYCLES=4 and no ack, bus_req SHALL be high for exactly 4 cycles, followed by complete with fault=1, and dmem_din SHALL be unchanged.
REQ-039 Asserting rst in the second BUS cycle SHALL force all outputs to 0 in the next cycle, and a subsequent stray ack SHALL produce no complete pulse.
